// File: rtl/io_peripheral_responder.sv
// Memory-mapped I/O responder: GPIO, free-running timer with compare IRQ, and a
// FIFO-buffered 8N1 UART transmitter behind one 4 KiB window.
module io_peripheral_responder #(
   parameter logic [19:0] BASE         = 20'h000F0,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] io_address,
   input  logic [31:0] io_write_value,
   output logic [31:0] io_read_value,
   input  logic        io_write_en,
   input  logic        io_read_en,
   input  logic [2:0]  io_data_size,
   output logic [7:0]  gpio_out,
   input  logic [7:0]  gpio_in,
   output logic        uart_tx,
   output logic        irq_timer
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(CLKS_PER_BIT);

   localparam logic [9:0] RegGpioOut = 10'd0;
   localparam logic [9:0] RegGpioIn  = 10'd1;
   localparam logic [9:0] RegTimer   = 10'd2;
   localparam logic [9:0] RegCmp     = 10'd3;
   localparam logic [9:0] RegUart    = 10'd4;
   localparam logic [9:0] RegStatus  = 10'd5;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [7:0]      gpio_q, sync1_q, sync2_q;
   logic [31:0]     timer_q, timer_d, cmp_q;
   logic            match_q, match_d, overflow_q, overflow_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q, count_d;
   logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            pop, push, full, empty, bit_done;

   logic            hit;
   logic [9:0]      sel;
   logic [1:0]      lane;
   logic [31:0]     wmask, wdata_al, wd_masked, rreg, status;
   logic [7:0]      rbyte;
   logic [15:0]     rhalf;

   assign hit  = io_address[31:12] == BASE;
   assign sel  = io_address[11:2];
   assign lane = io_address[1:0];

   // Replicate the right-aligned write data onto every lane and mask the target lane.
   always_comb begin
      wmask    = 32'hFFFF_FFFF;
      wdata_al = io_write_value;
      case (io_data_size[1:0])
         2'b00: begin
            wmask    = 32'h0000_00FF << {lane, 3'b000};
            wdata_al = {4{io_write_value[7:0]}};
         end
         2'b01: begin
            wmask    = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            wdata_al = {2{io_write_value[15:0]}};
         end
         default: ;
      endcase
   end

   assign wd_masked = wdata_al & wmask;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] m,
                                         input logic [31:0] d);
      return (old & ~m) | (d & m);
   endfunction

   logic we_gpio, we_timer, we_cmp, we_uart, we_status;
   assign we_gpio   = io_write_en && hit && (sel == RegGpioOut);
   assign we_timer  = io_write_en && hit && (sel == RegTimer);
   assign we_cmp    = io_write_en && hit && (sel == RegCmp);
   assign we_uart   = io_write_en && hit && (sel == RegUart);
   assign we_status = io_write_en && hit && (sel == RegStatus);

   assign full  = count_q == (AW+1)'(FIFO_DEPTH);
   assign empty = count_q == '0;
   assign push  = we_uart && !full;

   assign status = {19'b0, 5'(count_q), 3'b0, match_q, overflow_q, (state_q != StIdle),
                    empty, full};

   always_comb begin
      rreg = '0;
      if (hit && io_read_en) begin
         case (sel)
            RegGpioOut: rreg = {24'b0, gpio_q};
            RegGpioIn:  rreg = {24'b0, sync2_q};
            RegTimer:   rreg = timer_q;
            RegCmp:     rreg = cmp_q;
            RegStatus:  rreg = status;
            default:    rreg = '0;
         endcase
      end
   end

   assign rbyte = 8'(rreg >> {lane, 3'b000});
   assign rhalf = lane[1] ? rreg[31:16] : rreg[15:0];

   always_comb begin
      case (io_data_size)
         3'b000:  io_read_value = {{24{rbyte[7]}}, rbyte};
         3'b001:  io_read_value = {{16{rhalf[15]}}, rhalf};
         3'b100:  io_read_value = {24'b0, rbyte};
         3'b101:  io_read_value = {16'b0, rhalf};
         default: io_read_value = rreg;
      endcase
   end

   always_comb begin
      timer_d = we_timer ? merge(timer_q, wmask, wdata_al) : timer_q + 32'd1;
      // Set beats a same-edge w1c clear.
      match_d = match_q;
      if (we_status && wd_masked[4]) match_d = 1'b0;
      if (timer_q == cmp_q)          match_d = 1'b1;
      overflow_d = overflow_q;
      if (we_status && wd_masked[3]) overflow_d = 1'b0;
      if (we_uart && full)           overflow_d = 1'b1;
   end

   assign bit_done = clk_cnt_q == CW'(CLKS_PER_BIT - 1);

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      uart_tx   = 1'b1;
      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_d   = fifo_q[rd_ptr_q];
               clk_cnt_d = '0;
               state_d   = StStart;
            end
         end
         StStart: begin
            uart_tx = 1'b0;
            if (bit_done) begin
               clk_cnt_d = '0;
               bit_d     = '0;
               state_d   = StData;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
         StData: begin
            uart_tx = shift_q[0];
            if (bit_done) begin
               clk_cnt_d = '0;
               shift_d   = shift_q >> 1;
               if (bit_q == 3'd7) state_d = StStop;
               else bit_d = bit_q + 3'd1;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
         StStop: begin
            if (bit_done) begin
               clk_cnt_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_q[rd_ptr_q];
                  state_d = StStart;
               end else state_d = StIdle;
            end else clk_cnt_d = clk_cnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= io_write_value[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         gpio_q     <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         timer_q    <= '0;
         cmp_q      <= 32'hFFFF_FFFF;
         match_q    <= 1'b0;
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         clk_cnt_q  <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         if (we_gpio) gpio_q <= 8'(merge({24'b0, gpio_q}, wmask, wdata_al));
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         timer_q    <= timer_d;
         if (we_cmp) cmp_q <= merge(cmp_q, wmask, wdata_al);
         match_q    <= match_d;
         overflow_q <= overflow_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
      end
   end

   assign gpio_out  = gpio_q;
   assign irq_timer = match_q;

endmodule

// File: tb/tb_io_peripheral_responder.sv
// Directed bench for io_peripheral_responder; UART frames are checked against a
// queue of expected bytes filled as each byte is pushed.
`timescale 1ns/1ps
module tb_io_peripheral_responder;

   localparam int unsigned Cpb = 4;
   localparam logic [31:0] AGpio   = 32'h000F_0000;
   localparam logic [31:0] AGpioIn = 32'h000F_0004;
   localparam logic [31:0] ATimer  = 32'h000F_0008;
   localparam logic [31:0] ACmp    = 32'h000F_000C;
   localparam logic [31:0] AUart   = 32'h000F_0010;
   localparam logic [31:0] AStat   = 32'h000F_0014;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] io_address = '0;
   logic [31:0] io_write_value = '0;
   logic [31:0] io_read_value;
   logic        io_write_en = 1'b0;
   logic        io_read_en = 1'b0;
   logic [2:0]  io_data_size = 3'b010;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_in = '0;
   logic        uart_tx;
   logic        irq_timer;

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q [$];

   io_peripheral_responder #(
      .BASE         (20'h000F0),
      .CLKS_PER_BIT (Cpb),
      .FIFO_DEPTH   (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .io_address     (io_address),
      .io_write_value (io_write_value),
      .io_read_value  (io_read_value),
      .io_write_en    (io_write_en),
      .io_read_en     (io_read_en),
      .io_data_size   (io_data_size),
      .gpio_out       (gpio_out),
      .gpio_in        (gpio_in),
      .uart_tx        (uart_tx),
      .irq_timer      (irq_timer)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
      io_address     = addr;
      io_write_value = data;
      io_data_size   = size;
      io_write_en    = 1'b1;
      tick();
      io_write_en    = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] exp);
      io_address   = addr;
      io_data_size = size;
      io_read_en   = 1'b1;
      #1;
      chk(tag, io_read_value, exp);
      io_read_en   = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      wr(AUart, {24'hABCDEF, b}, 3'b000);
      if (accepted) exp_q.push_back(b);
   endtask

   // Entered just after the edge that starts the frame; returns just after its last edge.
   task automatic frame();
      logic [7:0] b;
      logic [9:0] f;
      if (exp_q.size() == 0) begin
         chk("uart_queue_empty", 32'd0, 32'd1);
         b = 8'h00;
      end else b = exp_q.pop_front();
      f = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < int'(Cpb); c++) begin
            chk($sformatf("uart_bit%0d_b%02h", i, b), {31'b0, uart_tx}, {31'b0, f[i]});
            tick();
         end
      end
   endtask

   initial begin
      // Reset
      tick();
      tick();
      chk("rst_gpio_out", {24'b0, gpio_out}, 32'h0);
      chk("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
      chk("rst_irq", {31'b0, irq_timer}, 32'h0);
      reset = 1'b0;
      rd("rst_status", AStat, 3'b010, 32'h0000_0002);
      rd("rst_cmp", ACmp, 3'b010, 32'hFFFF_FFFF);

      // Sized access on GPIO_OUT
      wr(AGpio, 32'h1234_5680, 3'b010);
      chk("sw_gpio_out", {24'b0, gpio_out}, 32'h80);
      rd("lb_gpio", AGpio, 3'b000, 32'hFFFF_FF80);
      rd("lbu_gpio", AGpio, 3'b100, 32'h0000_0080);
      rd("lw_gpio_upper0", AGpio, 3'b010, 32'h0000_0080);
      wr(AGpio, 32'h0000_005A, 3'b000);
      chk("sb_gpio_out", {24'b0, gpio_out}, 32'h5A);
      rd("lw_gpio_5a", AGpio, 3'b010, 32'h0000_005A);

      // Sized access on TIMER_CMP lanes
      wr(ACmp, 32'h1122_3344, 3'b010);
      wr(ACmp + 32'd1, 32'h0000_00AB, 3'b000);
      rd("cmp_lw_sb1", ACmp, 3'b010, 32'h1122_AB44);
      rd("cmp_lh_hi", ACmp + 32'd2, 3'b001, 32'h0000_1122);
      rd("cmp_lh_lo", ACmp, 3'b001, 32'hFFFF_AB44);
      rd("cmp_lhu_lo", ACmp, 3'b101, 32'h0000_AB44);
      rd("cmp_lb_1", ACmp + 32'd1, 3'b000, 32'hFFFF_FFAB);
      wr(ACmp + 32'd2, 32'h0000_8001, 3'b001);
      rd("cmp_sh_hi", ACmp, 3'b010, 32'h8001_AB44);

      // GPIO_IN synchronizer latency
      gpio_in = 8'h3C;
      tick();
      rd("gpio_in_1cyc", AGpioIn, 3'b010, 32'h0);
      tick();
      rd("gpio_in_2cyc", AGpioIn, 3'b010, 32'h3C);

      // Timer compare and IRQ
      wr(ATimer, 32'h0, 3'b010);
      rd("timer_after_load", ATimer, 3'b010, 32'h0);
      wr(ACmp, 32'd10, 3'b010);
      for (int k = 2; k <= 11; k++) begin
         tick();
         chk($sformatf("irq_edge%0d", k), {31'b0, irq_timer}, {31'b0, k == 11});
         if (k == 5) rd("timer_count5", ATimer, 3'b010, 32'd5);
      end
      rd("status_match", AStat, 3'b010, 32'h0000_0012);
      wr(AStat, 32'h0000_0010, 3'b010);
      chk("irq_cleared", {31'b0, irq_timer}, 32'h0);
      rd("status_after_clr", AStat, 3'b010, 32'h0000_0002);

      // UART single byte
      push_byte(8'hA5, 1'b1);
      rd("status_one_queued", AStat, 3'b010, 32'h0000_0100);
      chk("uart_idle_at_push", {31'b0, uart_tx}, 32'h1);
      tick();
      frame();
      rd("status_after_frame", AStat, 3'b010, 32'h0000_0002);

      // FIFO fill, overflow and back-to-back frames
      fork
         begin
            for (int i = 0; i < 10; i++) push_byte(8'h30 + 8'(i), i < 9);
            rd("status_full_ovf", AStat, 3'b010, 32'h0000_080D);
         end
         begin
            tick();
            tick();
            repeat (9) frame();
         end
      join
      rd("status_drained", AStat, 3'b010, 32'h0000_000A);
      chk("uart_idle_after", {31'b0, uart_tx}, 32'h1);
      chk("sb_queue_drained", exp_q.size(), 32'd0);
      wr(AStat, 32'h0000_0008, 3'b010);
      rd("status_ovf_clr", AStat, 3'b010, 32'h0000_0002);

      // Decode
      wr(32'h000E_0000, 32'h0000_00FF, 3'b010);
      chk("miss_gpio_unchanged", {24'b0, gpio_out}, 32'h5A);
      wr(32'h000E_0010, 32'h0000_0041, 3'b010);
      rd("miss_uart_no_push", AStat, 3'b010, 32'h0000_0002);
      rd("unmapped_0x18", 32'h000F_0018, 3'b010, 32'h0);
      rd("uart_reads_zero", AUart, 3'b010, 32'h0);
      io_address = AGpio;
      io_data_size = 3'b010;
      io_read_en = 1'b0;
      #1;
      chk("read_en_low", io_read_value, 32'h0);

      // Reset mid-frame
      push_byte(8'h00, 1'b0);
      push_byte(8'h77, 1'b0);
      repeat (6) tick();
      chk("midframe_low", {31'b0, uart_tx}, 32'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midframe_rst_tx", {31'b0, uart_tx}, 32'h1);
      chk("midframe_rst_gpio", {24'b0, gpio_out}, 32'h0);
      rd("midframe_rst_timer", ATimer, 3'b010, 32'h0);
      rd("midframe_rst_status", AStat, 3'b010, 32'h0000_0002);
      repeat (8) tick();
      chk("midframe_fifo_gone", {31'b0, uart_tx}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
